mmio_uart_fifo_ctrl: RTL

- Parametrised successor to the CPU's memory-mapped UART decode path.
- Adds RX and TX FIFOs of configurable depth between the pipeline and the UART.
- Adds free-running cycle and retired-instruction counters.
- Sits beside dmem:
  - Stage Y drives address, strobes and store data.
  - Stage Z consumes the registered read data when address[31:28] matches BASE_NIB.

---
 rtl/mmio_uart_fifo_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// mmio_uart_fifo_ctrl
// Memory-mapped UART block for the CPU. It sits beside dmem and provides RX
// and TX FIFOs between the pipeline and the UART, plus free-running cycle
// and retired-instruction counters.
//
// Optional feature: define MMIO_FIFO_LEVEL_EN to make offset 0x1C return the
// FIFO occupancy levels. When it is undefined, 0x1C reads 0 and no level
// logic is built.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   stall           pipeline stall; blocks CPU-side state changes
//   addr            stage-Y byte address; addr[31:28] selects the block,
//                   addr[7:0] selects the register
//   load_en         stage-Y load strobe
//   store_en        stage-Y store strobe
//   wdata           store byte
//   inst_retire     one instruction retires this cycle
//   rdata           registered load data for stage Z (one-cycle latency)
//   uart_tx_*       TX FIFO head toward the UART transmitter (valid/ready)
//   uart_rx_*       bytes from the UART receiver into the RX FIFO (valid/ready)
//
// Register map (offset = addr[7:0]):
//   0x00 R  bit0 = TX not full      0x04 R  bit0 = RX not empty
//   0x08 R  RX byte, pops RX FIFO   0x0C W  push wdata into TX FIFO
//   0x10 R  cycle count             0x14 R  instruction count
//   0x18 W  clear both counters     0x1C R  FIFO levels (optional)
// ---------------------------------------------------------------------------
module mmio_uart_fifo_ctrl #(
    parameter int unsigned RX_DEPTH  = 8,
    parameter int unsigned TX_DEPTH  = 8,
    parameter int unsigned CNT_WIDTH = 32,
    parameter logic [3:0]  BASE_NIB  = 4'h8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [31:0]          addr,
    input  logic                 load_en,
    input  logic                 store_en,
    input  logic [7:0]           wdata,
    input  logic                 inst_retire,
    output logic [31:0]          rdata,
    output logic [7:0]           uart_tx_data,
    output logic                 uart_tx_valid,
    input  logic                 uart_tx_ready,
    input  logic [7:0]           uart_rx_data,
    input  logic                 uart_rx_valid,
    output logic                 uart_rx_ready
);

    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam int unsigned RX_PW = RX_AW + 1;
    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned TX_PW = TX_AW + 1;

    localparam logic [7:0] OFF_TX_ST  = 8'h00;
    localparam logic [7:0] OFF_RX_ST  = 8'h04;
    localparam logic [7:0] OFF_RX_DAT = 8'h08;
    localparam logic [7:0] OFF_TX_DAT = 8'h0C;
    localparam logic [7:0] OFF_CYC    = 8'h10;
    localparam logic [7:0] OFF_INST   = 8'h14;
    localparam logic [7:0] OFF_CLR    = 8'h18;
    localparam logic [7:0] OFF_LVL    = 8'h1C;

    logic [7:0]           r_rx_mem [RX_DEPTH];
    logic [7:0]           r_tx_mem [TX_DEPTH];
    logic [RX_PW-1:0]     r_rx_wr, r_rx_rd;
    logic [TX_PW-1:0]     r_tx_wr, r_tx_rd;
    logic [CNT_WIDTH-1:0] r_cyc, r_inst;

    logic       w_hit, w_cpu_ok, w_ld, w_st;
    logic [7:0] w_off;
    logic       w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    logic       w_rx_push, w_rx_pop, w_tx_push, w_tx_pop, w_clr;
    logic [7:0] w_rx_head;
    logic [31:0] w_rd_val;
    logic       w_unused_addr;

    // Address decode and CPU-side qualification
    assign w_hit         = (addr[31:28] == BASE_NIB);
    assign w_off         = addr[7:0];
    assign w_unused_addr = ^addr[27:8];
    assign w_cpu_ok      = w_hit & ~stall;
    assign w_ld          = load_en  & w_cpu_ok;
    assign w_st          = store_en & w_cpu_ok;

    // Full when index bits match and wrap bits differ; empty when equal
    assign w_rx_empty = (r_rx_wr == r_rx_rd);
    assign w_rx_full  = (r_rx_wr[RX_AW-1:0] == r_rx_rd[RX_AW-1:0]) &&
                        (r_rx_wr[RX_AW] != r_rx_rd[RX_AW]);
    assign w_tx_empty = (r_tx_wr == r_tx_rd);
    assign w_tx_full  = (r_tx_wr[TX_AW-1:0] == r_tx_rd[TX_AW-1:0]) &&
                        (r_tx_wr[TX_AW] != r_tx_rd[TX_AW]);

    assign uart_rx_ready = ~w_rx_full;
    assign uart_tx_valid = ~w_tx_empty;
    assign uart_tx_data  = r_tx_mem[r_tx_rd[TX_AW-1:0]];
    assign w_rx_head     = r_rx_mem[r_rx_rd[RX_AW-1:0]];

    // A pop frees the head slot on the same edge, so a push to a full TX
    // FIFO is accepted when the UART drains it in that cycle.
    assign w_rx_push = uart_rx_valid & ~w_rx_full;
    assign w_rx_pop  = w_ld & (w_off == OFF_RX_DAT) & ~w_rx_empty;
    assign w_tx_pop  = ~w_tx_empty & uart_tx_ready;
    assign w_tx_push = w_st & (w_off == OFF_TX_DAT) & (~w_tx_full | w_tx_pop);
    assign w_clr     = w_st & (w_off == OFF_CLR);

`ifdef MMIO_FIFO_LEVEL_EN
    // Pointer difference taken at pointer width so the wrap bit is honoured
    logic [RX_PW-1:0] w_rx_diff;
    logic [TX_PW-1:0] w_tx_diff;
    assign w_rx_diff = r_rx_wr - r_rx_rd;
    assign w_tx_diff = r_tx_wr - r_tx_rd;
`endif

    // Read mux for the addressed register
    always_comb begin
        w_rd_val = '0;
        case (w_off)
            OFF_TX_ST:  w_rd_val = {31'd0, ~w_tx_full};
            OFF_RX_ST:  w_rd_val = {31'd0, ~w_rx_empty};
            OFF_RX_DAT: if (!w_rx_empty) w_rd_val = {24'd0, w_rx_head};
            OFF_CYC:    w_rd_val = 32'(r_cyc);
            OFF_INST:   w_rd_val = 32'(r_inst);
`ifdef MMIO_FIFO_LEVEL_EN
            OFF_LVL:    w_rd_val = {8'd0, 8'(w_tx_diff), 8'd0, 8'(w_rx_diff)};
`else
            OFF_LVL:    w_rd_val = '0;
`endif
            default:    w_rd_val = '0;
        endcase
    end

    // FIFO storage (contents need no reset)
    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wr[RX_AW-1:0]] <= uart_rx_data;
        if (w_tx_push) r_tx_mem[r_tx_wr[TX_AW-1:0]] <= wdata;
    end

    // FIFO pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_wr <= '0;
            r_rx_rd <= '0;
            r_tx_wr <= '0;
            r_tx_rd <= '0;
        end else begin
            if (w_rx_push) r_rx_wr <= r_rx_wr + RX_PW'(1);
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + RX_PW'(1);
            if (w_tx_push) r_tx_wr <= r_tx_wr + TX_PW'(1);
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + TX_PW'(1);
        end
    end

    // Counters; a clear takes priority over that cycle's increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc  <= '0;
            r_inst <= '0;
        end else if (w_clr) begin
            r_cyc  <= '0;
            r_inst <= '0;
        end else begin
            r_cyc <= r_cyc + CNT_WIDTH'(1);
            if (inst_retire && !stall) r_inst <= r_inst + CNT_WIDTH'(1);
        end
    end

    // Registered load data, held between qualified loads
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       rdata <= '0;
        else if (w_ld) rdata <= w_rd_val;
    end

endmodule
